// File: rtl/rgb_button_controller.sv
// Debounced 3-button front end driving four registered RGB LEDs.
// BTN1 selects an LED, BTN2 steps its colour, BTN3 clears all colours.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   BTN1..BTN3        raw asynchronous buttons, active-high
//   redN/greenN/blueN registered colour channels of LED N (1..4)
//   sel               registered index of the selected LED (0..3)
module rgb_button_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  output logic       red1,
  output logic       green1,
  output logic       blue1,
  output logic       red2,
  output logic       green2,
  output logic       blue2,
  output logic       red3,
  output logic       green3,
  output logic       blue3,
  output logic       red4,
  output logic       green4,
  output logic       blue4,
  output logic [1:0] sel
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       btn;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       stable;
  logic [2:0]       stable_d;
  logic [2:0]       press;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       col [4];

  // bit 0 = BTN1 (select), 1 = BTN2 (colour), 2 = BTN3 (clear)
  assign btn = {BTN3, BTN2, BTN1};

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // A single matching cycle restarts the count, so the level
  // only moves after DEBOUNCE_CYCLES unbroken mismatches.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 3; i++)
        cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = stable & ~stable_d;

  // Clear wins over colour step; the step uses the pre-advance
  // select, and select advances independently of both.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sel <= '0;
      for (int i = 0; i < 4; i++)
        col[i] <= '0;
    end else begin
      if (press[2]) begin
        for (int i = 0; i < 4; i++)
          col[i] <= '0;
      end else if (press[1]) begin
        col[sel] <= col[sel] + 3'd1;
      end
      if (press[0])
        sel <= sel + 2'd1;
    end
  end

  assign {red1, green1, blue1} = col[0];
  assign {red2, green2, blue2} = col[1];
  assign {red3, green3, blue3} = col[2];
  assign {red4, green4, blue4} = col[3];

endmodule
